// File: rtl/div_pkg.sv
// Shared definitions for the serial divisibility checker: register map,
// bus widths, divisor reset value and FSM state encoding.
package div_pkg;

   localparam int REG_ADDR_SZ = 8;
   localparam int REG_DATA_SZ = 32;

   localparam logic [REG_ADDR_SZ-1:0] ADDR_DIVISOR = 8'h04;
   localparam logic [REG_ADDR_SZ-1:0] ADDR_COUNT   = 8'h05;
   localparam logic [REG_ADDR_SZ-1:0] ADDR_STATUS  = 8'h06;

   localparam int DIVISOR_RST    = 3;
   localparam int STATUS_REM_LSB = 8;

   typedef enum logic {
      IDLE,
      ACCUM
   } div_state_t;

endpackage

// File: rtl/div_checker_if.sv
// Serial operand stream, result strobe and register bus of the divisibility
// checker, bundled so the parent and the block share one port group.
interface div_checker_if;
   import div_pkg::*;

   logic                   data_bit;
   logic                   data_vld;
   logic                   data_last;
   logic                   divisible;
   logic                   result_vld;
   logic                   reg_rd_en;
   logic                   reg_wr_en;
   logic [REG_ADDR_SZ-1:0] reg_addr;
   logic [REG_DATA_SZ-1:0] reg_wr_data;
   logic [REG_DATA_SZ-1:0] reg_rd_data;

   modport master (
      output data_bit, data_vld, data_last,
      output reg_rd_en, reg_wr_en, reg_addr, reg_wr_data,
      input  divisible, result_vld, reg_rd_data
   );

   modport slave (
      input  data_bit, data_vld, data_last,
      input  reg_rd_en, reg_wr_en, reg_addr, reg_wr_data,
      output divisible, result_vld, reg_rd_data
   );

endinterface

// File: rtl/div_rem_step.sv
// One Horner step of the running remainder: shifts in one operand bit and
// reduces modulo the divisor, assuming rem_in is already below the divisor.
module div_rem_step #(
   parameter int DIV_SZ = 8
) (
   input  logic [DIV_SZ-1:0] rem_in,
   input  logic              bit_in,
   input  logic [DIV_SZ-1:0] div,
   output logic [DIV_SZ-1:0] rem_out
);

   // One extra bit: 2*rem+bit can reach 2*div-1, so a single subtraction suffices.
   logic [DIV_SZ:0] shifted;
   logic [DIV_SZ:0] div_ext;

   assign shifted = {rem_in, bit_in};
   assign div_ext = {1'b0, div};

   always_comb begin
      rem_out = '0;
      if (div != '0) begin
         if (shifted >= div_ext) begin
            rem_out = DIV_SZ'(shifted - div_ext);
         end else begin
            rem_out = DIV_SZ'(shifted);
         end
      end
   end

endmodule

// File: rtl/div_checker.sv
// Serial divisibility checker: accumulates an MSB-first operand modulo a
// per-frame divisor and strobes a divisible flag one cycle after the last bit.
module div_checker
   import div_pkg::*;
#(
   parameter int DIV_SZ = 8
) (
   input logic          clk,
   input logic          rst,
   div_checker_if.slave bus
);

   div_state_t             state;
   logic [DIV_SZ-1:0]      divisor;
   logic [DIV_SZ-1:0]      active_div;
   logic [DIV_SZ-1:0]      rem;
   logic [DIV_SZ-1:0]      status_rem;
   logic [DIV_SZ-1:0]      step_rem_in;
   logic [DIV_SZ-1:0]      step_div;
   logic [DIV_SZ-1:0]      step_rem_out;
   logic                   first_bit;
   logic                   result_vld_q;
   logic                   divisible_q;
   logic [REG_DATA_SZ-1:0] rd_data;
   logic                   unused_wr_hi;

   // The first bit of a frame starts from zero and already uses the divisor
   // being latched, so the frame never sees a stale active_div.
   assign first_bit   = (state == IDLE);
   assign step_rem_in = first_bit ? '0 : rem;
   assign step_div    = first_bit ? divisor : active_div;

   div_rem_step #(
      .DIV_SZ (DIV_SZ)
   ) u_rem_step (
      .rem_in  (step_rem_in),
      .bit_in  (bus.data_bit),
      .div     (step_div),
      .rem_out (step_rem_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         divisor <= DIV_SZ'(DIVISOR_RST);
      end else if (bus.reg_wr_en && (bus.reg_addr == ADDR_DIVISOR)) begin
         divisor <= bus.reg_wr_data[DIV_SZ-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rem          <= '0;
         active_div   <= DIV_SZ'(DIVISOR_RST);
         status_rem   <= '0;
         result_vld_q <= 1'b0;
         divisible_q  <= 1'b0;
      end else begin
         result_vld_q <= 1'b0;
         if (bus.data_vld) begin
            rem <= step_rem_out;
            if (state == IDLE) begin
               active_div <= divisor;
            end
            if (bus.data_last) begin
               state        <= IDLE;
               result_vld_q <= 1'b1;
               divisible_q  <= (step_div != '0) && (step_rem_out == '0);
               status_rem   <= step_rem_out;
            end else begin
               state <= ACCUM;
            end
         end
      end
   end

   // Unselected reads return zero so the parent can OR all slaves together.
   always_comb begin
      rd_data = '0;
      if (bus.reg_rd_en) begin
         case (bus.reg_addr)
            ADDR_DIVISOR: rd_data = REG_DATA_SZ'(divisor);
            ADDR_STATUS: begin
               rd_data[0]                        = (state == ACCUM);
               rd_data[STATUS_REM_LSB +: DIV_SZ] = status_rem;
            end
            default: rd_data = '0;
         endcase
      end
   end

   assign unused_wr_hi    = ^bus.reg_wr_data[REG_DATA_SZ-1:DIV_SZ];
   assign bus.reg_rd_data = rd_data;
   assign bus.result_vld  = result_vld_q;
   assign bus.divisible   = divisible_q;

endmodule

// File: tb/tb_div_checker.sv
// Directed bench for div_checker: a small arithmetic model fills a scoreboard
// of expected results which a negedge monitor pops when they fall due.
module tb_div_checker;
   import div_pkg::*;

   typedef struct {
      int         due;
      logic       divisible;
      logic [7:0] rem;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   div_checker_if bus ();

   div_checker #(
      .DIV_SZ (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t       sb[$];
   int         cyc   = 0;
   int         total = 0;
   int         bad   = 0;
   int         curDiv = DIVISOR_RST;
   int         frameDiv = DIVISOR_RST;
   logic       modelInFrame = 1'b0;
   longint     acc = 0;
   logic [7:0] lastRem = 8'd0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A result must appear exactly in the cycle it falls due and never otherwise.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         checkOutput("result_vld", 32'(bus.result_vld), 32'd1);
         checkOutput("divisible", 32'(bus.divisible), 32'(e.divisible));
      end else if (bus.result_vld !== 1'b0) begin
         checkOutput("spurious_result_vld", 32'(bus.result_vld), 32'd0);
      end
   end

   task automatic driveQuiet();
      rst             = 1'b0;
      bus.data_vld    = 1'b0;
      bus.data_last   = 1'b0;
      bus.reg_wr_en   = 1'b0;
      bus.reg_rd_en   = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] bits, input int n, input logic last,
                                input int wrAt = -1, input logic [7:0] wrVal = 8'd0);
      for (int i = n - 1; i >= 0; i--) begin
         int   k;
         int   r;
         exp_t e;
         k = n - 1 - i;
         @(negedge clk);
         driveQuiet();
         bus.reg_wr_en   = (k == wrAt);
         bus.reg_addr    = ADDR_DIVISOR;
         bus.reg_wr_data = 32'(wrVal);
         bus.data_bit    = bits[i];
         bus.data_vld    = 1'b1;
         bus.data_last   = last && (i == 0);
         if (!modelInFrame) begin
            frameDiv     = curDiv;
            acc          = 0;
            modelInFrame = 1'b1;
         end
         acc = acc * 2 + longint'(bits[i]);
         if (k == wrAt) curDiv = int'(wrVal);
         if (bus.data_last) begin
            r           = (frameDiv == 0) ? 0 : int'(acc % longint'(frameDiv));
            e.due       = cyc + 1;
            e.divisible = (frameDiv != 0) && (r == 0);
            e.rem       = 8'(r);
            sb.push_back(e);
            lastRem      = 8'(r);
            modelInFrame = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         driveQuiet();
      end
   endtask

   task automatic writeReg(input logic [7:0] val);
      @(negedge clk);
      driveQuiet();
      bus.reg_wr_en   = 1'b1;
      bus.reg_addr    = ADDR_DIVISOR;
      bus.reg_wr_data = 32'(val);
      curDiv          = int'(val);
   endtask

   task automatic checkReg(input string tag, input logic [7:0] addr, input logic en,
                           input logic [31:0] exp);
      @(negedge clk);
      driveQuiet();
      bus.reg_rd_en = en;
      bus.reg_addr  = addr;
      #1;
      checkOutput(tag, bus.reg_rd_data, exp);
   endtask

   function automatic logic [31:0] statusExp(input logic inFrame);
      return (32'(lastRem) << STATUS_REM_LSB) | 32'(inFrame);
   endfunction

   // Leaves rst high so the next stimulus step releases it and drives a bit at once.
   task automatic doReset(input int n, input logic vldDuring);
      @(negedge clk);
      rst           = 1'b1;
      bus.data_vld  = vldDuring;
      bus.data_last = 1'b1;
      bus.data_bit  = 1'b1;
      bus.reg_wr_en = 1'b0;
      bus.reg_rd_en = 1'b0;
      repeat (n - 1) @(negedge clk);
      curDiv       = DIVISOR_RST;
      modelInFrame = 1'b0;
      lastRem      = 8'd0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst             = 1'b1;
      bus.data_bit    = 1'b0;
      bus.data_vld    = 1'b0;
      bus.data_last   = 1'b0;
      bus.reg_rd_en   = 1'b0;
      bus.reg_wr_en   = 1'b0;
      bus.reg_addr    = '0;
      bus.reg_wr_data = '0;

      doReset(3, 1'b0);
      idle(1);
      checkOutput("reset_result_vld", 32'(bus.result_vld), 32'd0);
      checkOutput("reset_divisible", 32'(bus.divisible), 32'd0);
      checkReg("divisor_after_reset", ADDR_DIVISOR, 1'b1, 32'd3);
      checkReg("count_addr_not_ours", ADDR_COUNT, 1'b1, 32'd0);
      checkReg("rd_en_low", ADDR_DIVISOR, 1'b0, 32'd0);
      checkReg("status_after_reset", ADDR_STATUS, 1'b1, 32'd0);

      applyStimulus(32'b110, 3, 1'b1);
      idle(2);
      checkReg("status_6_mod_3", ADDR_STATUS, 1'b1, statusExp(1'b0));

      applyStimulus(32'b111, 3, 1'b1);
      idle(2);
      checkReg("status_7_mod_3", ADDR_STATUS, 1'b1, statusExp(1'b0));

      applyStimulus(32'b111, 3, 1'b1);
      applyStimulus(32'b1001, 4, 1'b1);
      idle(2);
      checkReg("status_back_to_back", ADDR_STATUS, 1'b1, statusExp(1'b0));

      applyStimulus(32'b10, 2, 1'b0);
      idle(3);
      checkReg("status_in_frame", ADDR_STATUS, 1'b1, statusExp(1'b1));
      applyStimulus(32'b11, 2, 1'b1);
      idle(2);
      checkReg("status_11_mod_3", ADDR_STATUS, 1'b1, statusExp(1'b0));

      writeReg(8'd5);
      applyStimulus(32'b1010, 4, 1'b1, 2, 8'd4);
      applyStimulus(32'b100, 3, 1'b1);
      idle(2);
      checkReg("divisor_after_midframe_write", ADDR_DIVISOR, 1'b1, 32'd4);

      writeReg(8'd0);
      applyStimulus(32'b0, 1, 1'b1);
      idle(2);
      checkReg("status_div_zero", ADDR_STATUS, 1'b1, statusExp(1'b0));
      writeReg(8'd1);
      applyStimulus(32'b11, 2, 1'b1);
      idle(2);

      writeReg(8'd7);
      applyStimulus(32'hB5A3D, 20, 1'b1);
      idle(2);
      checkReg("status_long_mod_7", ADDR_STATUS, 1'b1, statusExp(1'b0));

      writeReg(8'd255);
      applyStimulus(32'hFFFFE, 20, 1'b1);
      idle(2);
      checkReg("status_long_mod_255", ADDR_STATUS, 1'b1, statusExp(1'b0));

      writeReg(8'd5);
      applyStimulus(32'b11, 2, 1'b0);
      doReset(2, 1'b1);
      applyStimulus(32'b0, 1, 1'b1);
      idle(2);
      checkReg("status_after_abort", ADDR_STATUS, 1'b1, statusExp(1'b0));
      checkReg("divisor_after_abort", ADDR_DIVISOR, 1'b1, 32'd3);

      idle(3);
      checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_checker.md
DIV_CHECKER -- requirements
Module: div_checker

Interface
REQ-001 Parameter DIV_SZ, default 8, width of divisor and remainder (DIV_SZ <= `REG_DATA_SZ).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 data_bit  input  1  serial operand bit, MSB first.
REQ-005 data_vld  input  1  data_bit valid this cycle; always accepted, no backpressure.
REQ-006 data_last  input  1  qualifies data_bit as the final (LSB) bit of the operand; ignored unless data_vld.
REQ-007 divisible  output  1  operand divisible by the frame's divisor; meaningful only with result_vld.
REQ-008 result_vld  output  1  one-cycle result strobe; feeds the downstream divisible-result counter.
REQ-009 reg_rd_en, reg_wr_en  input  1 each  register bus strobes.
REQ-010 reg_addr  input  `REG_ADDR_SZ  register address.
REQ-011 reg_wr_data  input  `REG_DATA_SZ  write data.
REQ-012 reg_rd_data  output  `REG_DATA_SZ  read data; all zeros unless a register of this block is read (parent ORs slaves).

Function
REQ-013 DIVISOR register at address 0x04, RW, bits [DIV_SZ-1:0], upper bits read 0, reset value 3.
REQ-014 STATUS register at address 0x06, RO: bit0 in_frame, bits [DIV_SZ+7:8] remainder of last completed operand; writes ignored.
REQ-015 Reads combinational: reg_rd_data = selected register when reg_rd_en and address match, else 0.
REQ-016 FSM states IDLE and ACCUM; IDLE after reset.
REQ-017 IDLE and data_vld: latch DIVISOR into active_div, rem <= step(0, data_bit); go ACCUM unless data_last.
REQ-018 ACCUM and data_vld: rem <= step(rem, data_bit) using active_div; data_last -> IDLE.
REQ-019 step(r,b): t = 2r+b computed at DIV_SZ+1 bits; result t-active_div if t >= active_div, else t.
REQ-020 Cycles without data_vld hold state and rem; no timeout.
REQ-021 result_vld asserts exactly one cycle after the data_vld&data_last cycle; divisible = (final rem == 0).
REQ-022 STATUS remainder updates in the same cycle result_vld asserts.
REQ-023 Single-bit frame (data_last on first bit) from IDLE is legal; result timing as REQ-021.
REQ-024 Back-to-back frames legal: first bit of next frame may arrive the cycle after data_last; no bubble required.
REQ-025 DIVISOR writes mid-frame take effect on the next frame only (active_div unchanged until IDLE load).
REQ-026 active_div == 0: rem held 0, result delivered on schedule with divisible=0, STATUS remainder 0.
REQ-027 active_div == 1: every operand reports divisible=1.
REQ-028 Operand length unbounded; rem never exceeds active_div-1.
REQ-029 Same-cycle register write and data bit: bit uses pre-write active_div; write lands per REQ-025.

Reset
REQ-030 rst: state IDLE, rem 0, active_div 3, DIVISOR 3, STATUS remainder 0, result_vld 0, divisible 0.
REQ-031 rst mid-frame aborts the frame; no result_vld for it; data_vld during rst ignored.
REQ-032 First frame accepted in the cycle after rst deasserts.

Structure
REQ-033 Shared package div_pkg holds register addresses (DIVISOR 0x04, COUNT 0x05, STATUS 0x06), DIVISOR reset value, FSM state enum.
REQ-034 Remainder update in sub-module div_rem_step (combinational, parameter DIV_SZ).
REQ-035 result_vld and divisible driven from flops.

Verification
REQ-036 DIVISOR=3, bits 1,1,0 (6) last on 0 -> next cycle result_vld=1, divisible=1, STATUS rem 0.
REQ-037 DIVISOR=3, bits 1,1,1 (7) -> divisible=0, STATUS rem 1; then frame 1,0,0,1 (9) back-to-back -> divisible=1.
REQ-038 DIVISOR=5, frame 1,0,1,0 (10) with write DIVISOR=4 after 2nd bit -> divisible=1 (uses 5); next frame 1,0,0 (4) -> divisible=1 (uses 4).
REQ-039 DIVISOR=0, frame 0 -> result_vld=1, divisible=0; DIVISOR=1, frame 1,1 -> divisible=1.
REQ-040 rst asserted after 2 bits of frame -> no result_vld; new frame 0 (single bit) -> divisible=1.
REQ-041 Reads: addr 0x04 -> 3 after reset; addr 0x05 -> 0 from this block; reg_rd_en low -> 0.
